opfetch: RTL and testbench

Operand-fetch stage directly upstream of the ALU. It accepts a decoded instruction, reads both source operands from an internal 16×32 register file, and issues a data-memory read for `OP_LD`/`OP_LDA`. It then holds `o_reg0`/`o_reg1`/`o_ram`/`o_inst`/`o_fmt` stable with `o_valid` until the downstream stage takes them. The register-file write port is driven by writeback.

---
 rtl/opfetch.sv | 186 ++++++++++++++++++
 tb/tb_opfetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opfetch.sv
// Operand-fetch stage: 16x32 register file with write bypass, optional data-memory
// read for loads, and a held output register set with a valid/ready handshake.
module opfetch #(
    parameter int NREGS = 16,
    parameter int W     = 32,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [3:0]    i_inst,
    input  logic [1:0]    i_fmt,
    input  logic [IW-1:0] i_rs0,
    input  logic [IW-1:0] i_rs1,
    input  logic [IW-1:0] i_rd,
    output logic          o_mem_req,
    output logic [W-1:0]  o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [W-1:0]  i_mem_data,
    input  logic          i_wb_en,
    input  logic [IW-1:0] i_wb_idx,
    input  logic [W-1:0]  i_wb_val,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [3:0]    o_inst,
    output logic [1:0]    o_fmt,
    output logic [IW-1:0] o_rd,
    output logic [W-1:0]  o_reg0,
    output logic [W-1:0]  o_reg1,
    output logic [W-1:0]  o_ram
);

    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_LDA = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   rf_r [NREGS];
    logic [W-1:0]   rd0_s;
    logic [W-1:0]   rd1_s;
    logic [W-1:0]   addr_s;
    logic           accept_s;
    logic           is_load_s;
    logic           ready_s;
    logic           valid_r;
    logic           mem_req_r;
    logic [W-1:0]   mem_addr_r;
    logic [3:0]     inst_r;
    logic [1:0]     fmt_r;
    logic [IW-1:0]  rd_r;
    logic [W-1:0]   reg0_r;
    logic [W-1:0]   reg1_r;
    logic [W-1:0]   ram_r;

    // Register file write port; r0 is never written so it stays zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {W{1'b0}};
            end
        end else if (i_wb_en && (i_wb_idx != {IW{1'b0}})) begin
            rf_r[i_wb_idx] <= i_wb_val;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        rd0_s = {W{1'b0}};
        rd1_s = {W{1'b0}};
        if (i_rs0 == {IW{1'b0}}) begin
            rd0_s = {W{1'b0}};
        end else if (i_wb_en && (i_wb_idx == i_rs0)) begin
            rd0_s = i_wb_val;
        end else begin
            rd0_s = rf_r[i_rs0];
        end
        if (i_rs1 == {IW{1'b0}}) begin
            rd1_s = {W{1'b0}};
        end else if (i_wb_en && (i_wb_idx == i_rs1)) begin
            rd1_s = i_wb_val;
        end else begin
            rd1_s = rf_r[i_rs1];
        end
    end

    // Handshake and load address decode.
    always_comb begin
        ready_s   = (state_r == ST_IDLE) || ((state_r == ST_OUT) && i_ready);
        accept_s  = i_valid && ready_s;
        is_load_s = (i_inst == OP_LD) || (i_inst == OP_LDA);
        if (i_inst == OP_LDA) begin
            addr_s = rd0_s + rd1_s;
        end else begin
            addr_s = rd0_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = is_load_s ? ST_MEM : ST_OUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_OUT: begin
                if (accept_s) begin
                    state_nxt_s = is_load_s ? ST_MEM : ST_OUT;
                end else if (i_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with handshake flags registered alongside it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            mem_req_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            valid_r   <= (state_nxt_s == ST_OUT);
            mem_req_r <= (state_nxt_s == ST_MEM);
        end
    end

    // Operand capture; values stay frozen until the next accept or ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_addr_r <= {W{1'b0}};
            inst_r     <= 4'h0;
            fmt_r      <= 2'b00;
            rd_r       <= {IW{1'b0}};
            reg0_r     <= {W{1'b0}};
            reg1_r     <= {W{1'b0}};
            ram_r      <= {W{1'b0}};
        end else if (accept_s) begin
            inst_r <= i_inst;
            fmt_r  <= i_fmt;
            rd_r   <= i_rd;
            reg0_r <= rd0_s;
            reg1_r <= rd1_s;
            if (is_load_s) begin
                mem_addr_r <= addr_s;
            end else begin
                ram_r <= {W{1'b0}};
            end
        end else if ((state_r == ST_MEM) && i_mem_ack) begin
            ram_r <= i_mem_data;
        end
    end

    assign o_ready    = ready_s;
    assign o_valid    = valid_r;
    assign o_mem_req  = mem_req_r;
    assign o_mem_addr = mem_addr_r;
    assign o_inst     = inst_r;
    assign o_fmt      = fmt_r;
    assign o_rd       = rd_r;
    assign o_reg0     = reg0_r;
    assign o_reg1     = reg1_r;
    assign o_ram      = ram_r;

endmodule

// File: tb/tb_opfetch.sv
// Scoreboard bench for opfetch: directed scenarios followed by randomized traffic,
// with a memory responder and a monitor that checks the DUT every cycle.
module tb_opfetch;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_LDA = 4'h9;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_inst;
    logic [1:0]  i_fmt;
    logic [3:0]  i_rs0;
    logic [3:0]  i_rs1;
    logic [3:0]  i_rd;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        i_wb_en;
    logic [3:0]  i_wb_idx;
    logic [31:0] i_wb_val;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_inst;
    logic [1:0]  o_fmt;
    logic [3:0]  o_rd;
    logic [31:0] o_reg0;
    logic [31:0] o_reg1;
    logic [31:0] o_ram;

    opfetch #(.NREGS(16), .W(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_fmt(i_fmt), .i_rs0(i_rs0), .i_rs1(i_rs1), .i_rd(i_rd),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_data(i_mem_data), .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx),
        .i_wb_val(i_wb_val), .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst),
        .o_fmt(o_fmt), .o_rd(o_rd), .o_reg0(o_reg0), .o_reg1(o_reg1), .o_ram(o_ram)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  inst;
        logic [1:0]  fmt;
        logic [3:0]  rd;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] addr;
        bit          ld;
        int          acc_edge;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mrf [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ack_edge_g = 0;
    bit          resp_en = 1'b1;
    int          fixed_wait = -1;
    int          wcnt = 0;
    int          tgt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    // Reference read: r0 is zero, a same-cycle write wins, else the stored value.
    function automatic logic [31:0] rdm(input logic [3:0] idx, input bit wen,
                                        input logic [3:0] widx, input logic [31:0] wval);
        if (idx == 4'd0) return 32'd0;
        if (wen && widx == idx) return wval;
        return mrf[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; records the expected result when the DUT takes it.
    task automatic step(input bit v, input logic [3:0] inst, input logic [3:0] rs0,
                        input logic [3:0] rs1, input bit wen, input logic [3:0] widx,
                        input logic [31:0] wval, input bit rdy, output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid  = v;
        i_inst   = inst;
        i_fmt    = 2'($urandom_range(0, 3));
        i_rs0    = rs0;
        i_rs1    = rs1;
        i_rd     = 4'($urandom_range(0, 15));
        i_wb_en  = wen;
        i_wb_idx = widx;
        i_wb_val = wval;
        i_ready  = rdy;
        @(negedge clk);
        acc = v && o_ready;
        if (acc) begin
            e.inst     = inst;
            e.fmt      = i_fmt;
            e.rd       = i_rd;
            e.r0       = rdm(rs0, wen, widx, wval);
            e.r1       = rdm(rs1, wen, widx, wval);
            e.ld       = (inst == OP_LD) || (inst == OP_LDA);
            e.addr     = (inst == OP_LDA) ? e.r0 + e.r1 : e.r0;
            e.acc_edge = cyc + 1;
            q.push_back(e);
        end
        if (wen && widx != 4'd0) mrf[widx] = wval;
    endtask

    task automatic issue(input logic [3:0] inst, input logic [3:0] rs0, input logic [3:0] rs1,
                         input bit wen, input logic [3:0] widx, input logic [31:0] wval);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            step(1'b1, inst, rs0, rs1, wen, widx, wval, 1'b1, acc);
            n++;
        end
        check("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Memory responder: acknowledges requests after a wait, sends stray acks otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                i_mem_ack = 1'b0;
                if (o_mem_req) begin
                    if (wcnt == 0) tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 4));
                    if (wcnt >= tgt) begin
                        i_mem_ack  = 1'b1;
                        i_mem_data = mem_f(o_mem_addr);
                        ack_edge_g = cyc + 1;
                        wcnt       = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                    if ($urandom_range(0, 7) == 0) begin
                        i_mem_ack  = 1'b1;
                        i_mem_data = $urandom;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: derive the expected stage condition from the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() == 0 || cyc < q[0].acc_edge) begin
                check("idle_valid", 32'(o_valid), 32'd0);
                check("idle_mem_req", 32'(o_mem_req), 32'd0);
                check("idle_ready", 32'(o_ready), 32'd1);
            end else if (q[0].ld && (ack_edge_g == 0 || cyc < ack_edge_g)) begin
                check("mem_req", 32'(o_mem_req), 32'd1);
                check("mem_valid", 32'(o_valid), 32'd0);
                check("mem_ready", 32'(o_ready), 32'd0);
                check("mem_addr", o_mem_addr, q[0].addr);
            end else begin
                check("out_valid", 32'(o_valid), 32'd1);
                check("out_mem_req", 32'(o_mem_req), 32'd0);
                check("out_ready", 32'(o_ready), 32'(i_ready));
                check("out_inst", 32'(o_inst), 32'(q[0].inst));
                check("out_fmt", 32'(o_fmt), 32'(q[0].fmt));
                check("out_rd", 32'(o_rd), 32'(q[0].rd));
                check("out_reg0", o_reg0, q[0].r0);
                check("out_reg1", o_reg1, q[0].r1);
                check("out_ram", o_ram, q[0].ld ? mem_f(q[0].addr) : 32'd0);
                if (i_ready) begin
                    if (q[0].ld) ack_edge_g = 0;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        bit acc;
        for (int i = 0; i < 16; i++) mrf[i] = 32'd0;
        i_rst = 1'b1; i_valid = 1'b0; i_inst = 4'd0; i_fmt = 2'd0; i_rs0 = 4'd0;
        i_rs1 = 4'd0; i_rd = 4'd0; i_mem_ack = 1'b0; i_mem_data = 32'd0;
        i_wb_en = 1'b0; i_wb_idx = 4'd0; i_wb_val = 32'd0; i_ready = 1'b1;
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_reg0", o_reg0, 32'd0);
        check("rst_reg1", o_reg1, 32'd0);
        check("rst_ram", o_ram, 32'd0);
        check("rst_inst_fmt_rd", {22'd0, o_inst, o_fmt, o_rd}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        i_rst = 1'b0;

        // Write then read, bypass, and r0 behaviour.
        step(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 4'd3, 32'h12345678, 1'b1, acc);
        issue(OP_ADD, 4'd3, 4'd0, 1'b0, 4'd0, 32'd0);
        issue(OP_ADD, 4'd5, 4'd3, 1'b1, 4'd5, 32'hA5A5A5A5);
        step(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, acc);
        issue(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        drain();

        // LDA with address wrap and three wait cycles.
        fixed_wait = 3;
        step(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 4'd1, 32'hFFFFFFF0, 1'b1, acc);
        step(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 4'd2, 32'h00000020, 1'b1, acc);
        issue(OP_LDA, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
        drain();
        fixed_wait = -1;

        // Back-to-back non-memory ops.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_ADD, 4'(i + 1), 4'(i + 3), 1'b0, 4'd0, 32'd0, 1'b1, acc);
            check("b2b_accept", 32'(acc), 32'd1);
        end
        drain();

        // Stall for five cycles, then release.
        issue(OP_ADD, 4'd3, 4'd5, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, OP_ADD, 4'd1, 4'd2, 1'b1, 4'd7, $urandom, 1'b0, acc);
            check("stall_no_accept", 32'(acc), 32'd0);
        end
        step(1'b1, OP_ADD, 4'd7, 4'd1, 1'b0, 4'd0, 32'd0, 1'b1, acc);
        check("stall_release_accept", 32'(acc), 32'd1);
        drain();

        // Reset during MEM, then a stray ack in IDLE.
        resp_en = 1'b0;
        i_mem_ack = 1'b0;
        issue(OP_LD, 4'd3, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(2);
        @(posedge clk); #3;
        i_rst = 1'b1;
        q.delete();
        ack_edge_g = 0;
        for (int i = 0; i < 16; i++) mrf[i] = 32'd0;
        #1;
        check("rst_mid_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #2;
        i_rst = 1'b0;
        @(posedge clk); #1;
        i_mem_ack = 1'b1;
        i_mem_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        idle(4);
        resp_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] inst;
            logic [3:0] rs0;
            logic [3:0] widx;
            int sel;
            sel  = int'($urandom_range(0, 3));
            inst = (sel == 0) ? OP_LD : (sel == 1) ? OP_LDA : 4'($urandom_range(0, 7));
            rs0  = 4'($urandom_range(0, 15));
            widx = ($urandom_range(0, 3) == 0) ? rs0 : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), inst, rs0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), widx, $urandom, ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
